// File: rtl/cam_capture_centroid_pkg.sv
// -----------------------------------------------------------------------------
// cam_capture_centroid_pkg
// Shared definitions for the OV7670 capture / colour-centroid block:
// stored image geometry, RGB444 field widths, default colour thresholds,
// capture FSM state encoding and the per-component threshold test.
// -----------------------------------------------------------------------------
package cam_capture_centroid_pkg;

   // stored (decimated) image, camera delivers twice this in each direction
   localparam int IMG_COLS    = 80;
   localparam int IMG_ROWS    = 60;
   localparam int NB_IMG_PXLS = 13;

   // counter widths: camera-side 0..255 / 0..127, stored-side 0..127 / 0..63
   localparam int NB_CAM_COL  = 8;
   localparam int NB_CAM_ROW  = 7;
   localparam int NB_COL      = 7;
   localparam int NB_ROW      = 6;

   // RGB444
   localparam int NB_COMP     = 4;
   localparam int NB_PXL      = 3 * NB_COMP;

   // default colour thresholds on a 4-bit component
   localparam int THR_HI      = 8;
   localparam int THR_LO      = 6;

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_ACTIVE = 2'd2
   } cam_state_t;

   typedef struct packed {
      logic [NB_COMP-1:0] r;
      logic [NB_COMP-1:0] g;
      logic [NB_COMP-1:0] b;
   } rgb444_t;

   // A component passes when it is high (filter bit 1) or low (filter bit 0).
   function automatic logic comp_pass(input logic [NB_COMP-1:0] comp,
                                      input logic               want_hi,
                                      input logic [NB_COMP-1:0] thr_hi,
                                      input logic [NB_COMP-1:0] thr_lo);
      return want_hi ? (comp >= thr_hi) : (comp < thr_lo);
   endfunction

endpackage

// File: rtl/cam_capture_centroid_bbox.sv
// -----------------------------------------------------------------------------
// bbox_centroid
// Tracks the bounding box of matching stored pixels over one frame and, at
// frame end, publishes its centre. With no match the previous centre is held
// and cent_valid drops.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   init                re-arm the box (frame start)
//   hit                 a matching pixel was stored this cycle
//   hit_col, hit_row    stored coordinates of that pixel
//   fin                 frame end: publish centre
//   cent_col, cent_row  centre of the box, truncated
//   cent_valid          1 when the finished frame had at least one match
// -----------------------------------------------------------------------------
module bbox_centroid
   import cam_capture_centroid_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              hit,
   input  logic [NB_COL-1:0] hit_col,
   input  logic [NB_ROW-1:0] hit_row,
   input  logic              fin,
   output logic [NB_COL-1:0] cent_col,
   output logic [NB_ROW-1:0] cent_row,
   output logic              cent_valid
);

   logic [NB_COL-1:0] min_col;
   logic [NB_COL-1:0] max_col;
   logic [NB_ROW-1:0] min_row;
   logic [NB_ROW-1:0] max_row;
   logic              found;

   // one extra bit so min+max cannot wrap before the halving
   logic [NB_COL:0]   sum_col;
   logic [NB_ROW:0]   sum_row;

   assign sum_col = {1'b0, min_col} + {1'b0, max_col};
   assign sum_row = {1'b0, min_row} + {1'b0, max_row};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min_col    <= '0;
         max_col    <= '0;
         min_row    <= '0;
         max_row    <= '0;
         found      <= 1'b0;
         cent_col   <= '0;
         cent_row   <= '0;
         cent_valid <= 1'b0;
      end else begin
         if (init) begin
            // min starts at all-ones, max at zero, so the first hit sets both
            min_col <= '1;
            max_col <= '0;
            min_row <= '1;
            max_row <= '0;
            found   <= 1'b0;
         end else if (hit) begin
            if (hit_col < min_col) min_col <= hit_col;
            if (hit_col > max_col) max_col <= hit_col;
            if (hit_row < min_row) min_row <= hit_row;
            if (hit_row > max_row) max_row <= hit_row;
            found <= 1'b1;
         end

         if (fin) begin
            if (found) begin
               cent_col   <= sum_col[NB_COL:1];
               cent_row   <= sum_row[NB_ROW:1];
               cent_valid <= 1'b1;
            end else begin
               cent_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/cam_capture_centroid.sv
// -----------------------------------------------------------------------------
// cam_capture_centroid
// OV7670 RGB444 capture into an 80x60 frame buffer (every second camera
// column and row of a 160x120 stream), with an optional {R,G,B} colour
// filter and a test-pattern mode. The bounding box of matching pixels is
// tracked and its centre reported once per frame.
//
// Ports
//   clk, rst_n             camera PCLK, synchronous active-low reset
//   cam_vsync, cam_href    camera frame / line strobes
//   cam_data[7:0]          RGB444 bytes: byte0[3:0]=R, byte1={G,B}
//   testmode               write column test pattern instead of camera data
//   rgbfilter[2:0]         {R,G,B} colour filter, 000 = pass everything
//   fb_we, fb_addr, fb_wdata  frame-buffer write port, R in [11:8]
//   cent_col, cent_row     centre of matching pixels of the last frame
//   cent_valid             last frame had at least one match
//   frame_done             one-cycle pulse at the end of each captured frame
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SYNC   | after reset; waits for a vsync pulse, nothing is written
// ST_VBLANK | vertical blank; address/counters cleared, waits vsync low
// ST_ACTIVE | frame data; pixels assembled, decimated, filtered, written
// -----------------------------------------------------------------------------
module cam_capture_centroid
   import cam_capture_centroid_pkg::*;
#(
   parameter int c_img_cols    = IMG_COLS,
   parameter int c_img_rows    = IMG_ROWS,
   parameter int c_nb_img_pxls = NB_IMG_PXLS,
   parameter int c_thr_hi      = THR_HI,
   parameter int c_thr_lo      = THR_LO
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cam_vsync,
   input  logic                     cam_href,
   input  logic [7:0]               cam_data,
   input  logic                     testmode,
   input  logic [2:0]               rgbfilter,
   output logic                     fb_we,
   output logic [c_nb_img_pxls-1:0] fb_addr,
   output logic [NB_PXL-1:0]        fb_wdata,
   output logic [NB_COL-1:0]        cent_col,
   output logic [NB_ROW-1:0]        cent_row,
   output logic                     cent_valid,
   output logic                     frame_done
);

   localparam logic [NB_CAM_COL-1:0]    COL_LIM  = NB_CAM_COL'(2 * c_img_cols);
   localparam logic [NB_CAM_ROW-1:0]    ROW_LIM  = NB_CAM_ROW'(2 * c_img_rows);
   localparam logic [c_nb_img_pxls-1:0] STRIDE   = c_nb_img_pxls'(c_img_cols);
   localparam logic [c_nb_img_pxls-1:0] ADDR_END = c_nb_img_pxls'(c_img_cols * c_img_rows);
   localparam logic [NB_COMP-1:0]       THR_H    = NB_COMP'(c_thr_hi);
   localparam logic [NB_COMP-1:0]       THR_L    = NB_COMP'(c_thr_lo);

   cam_state_t               state;
   logic                     href_d;
   logic                     phase;
   logic [NB_COMP-1:0]       r_hold;
   logic [NB_CAM_COL-1:0]    col_cnt;
   logic [NB_CAM_ROW-1:0]    row_cnt;
   logic [c_nb_img_pxls-1:0] row_base;
   logic [c_nb_img_pxls-1:0] addr_cnt;
   logic [2:0]               filt_q;
   logic                     tm_q;

   rgb444_t                  pix;
   logic                     pix_done;
   logic                     in_win;
   logic                     keep;
   logic                     match;
   logic                     hit;
   logic [NB_COL-1:0]        img_col;
   logic [NB_ROW-1:0]        img_row;
   logic [NB_PXL-1:0]        tp_pix;
   logic [NB_PXL-1:0]        src_pix;
   logic [NB_PXL-1:0]        wdata;
   logic                     bb_init;
   logic                     bb_fin;

   assign pix      = {r_hold, cam_data};
   assign img_col  = col_cnt[NB_CAM_COL-1:1];
   assign img_row  = row_cnt[NB_CAM_ROW-1:1];

   // a vsync edge wins over a second byte arriving in the same cycle, so a
   // pixel cut by the end of frame is simply dropped
   assign pix_done = (state == ST_ACTIVE) && !cam_vsync && cam_href && phase;
   assign in_win   = (col_cnt < COL_LIM) && (row_cnt < ROW_LIM) &&
                     !col_cnt[0] && !row_cnt[0] && (addr_cnt < ADDR_END);
   assign keep     = pix_done && in_win;

   assign match    = (filt_q != 3'b000) &&
                     comp_pass(pix.r, filt_q[2], THR_H, THR_L) &&
                     comp_pass(pix.g, filt_q[1], THR_H, THR_L) &&
                     comp_pass(pix.b, filt_q[0], THR_H, THR_L);
   assign hit      = keep && match;

   assign tp_pix   = {{NB_COMP{img_col[6]}}, {NB_COMP{img_col[5]}}, {NB_COMP{img_col[4]}}};
   assign src_pix  = tm_q ? tp_pix : pix;
   assign wdata    = ((filt_q == 3'b000) || match) ? src_pix : '0;

   assign bb_init  = (state == ST_VBLANK) && !cam_vsync;
   assign bb_fin   = (state == ST_ACTIVE) && cam_vsync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_SYNC;
         href_d     <= 1'b0;
         phase      <= 1'b0;
         r_hold     <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         row_base   <= '0;
         addr_cnt   <= '0;
         filt_q     <= '0;
         tm_q       <= 1'b0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_wdata   <= '0;
         frame_done <= 1'b0;
      end else begin
         fb_we      <= 1'b0;
         frame_done <= 1'b0;
         href_d     <= cam_href;

         case (state)
            ST_SYNC: begin
               phase <= 1'b0;
               if (cam_vsync) state <= ST_VBLANK;
            end

            ST_VBLANK: begin
               phase    <= 1'b0;
               col_cnt  <= '0;
               row_cnt  <= '0;
               row_base <= '0;
               addr_cnt <= '0;
               fb_addr  <= '0;
               if (!cam_vsync) begin
                  state  <= ST_ACTIVE;
                  filt_q <= rgbfilter;
                  tm_q   <= testmode;
               end
            end

            ST_ACTIVE: begin
               if (cam_vsync) begin
                  state      <= ST_VBLANK;
                  frame_done <= 1'b1;
                  phase      <= 1'b0;
               end else if (!cam_href) begin
                  phase   <= 1'b0;
                  col_cnt <= '0;
                  if (href_d) begin
                     if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
                     // after a stored (even) line the next stored line starts
                     // one stride further, however short this line was
                     if (!row_cnt[0] && (row_cnt < ROW_LIM)) begin
                        row_base <= row_base + STRIDE;
                        addr_cnt <= row_base + STRIDE;
                     end
                  end
               end else if (!phase) begin
                  phase  <= 1'b1;
                  r_hold <= cam_data[NB_COMP-1:0];
               end else begin
                  phase <= 1'b0;
                  if (col_cnt != '1) col_cnt <= col_cnt + 1'b1;
                  if (keep) begin
                     fb_we    <= 1'b1;
                     fb_addr  <= addr_cnt;
                     fb_wdata <= wdata;
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
            end

            default: state <= ST_SYNC;
         endcase
      end
   end

   bbox_centroid u_bbox (
      .clk        (clk),
      .rst_n      (rst_n),
      .init       (bb_init),
      .hit        (hit),
      .hit_col    (img_col),
      .hit_row    (img_row),
      .fin        (bb_fin),
      .cent_col   (cent_col),
      .cent_row   (cent_row),
      .cent_valid (cent_valid)
   );

endmodule

// File: tb/tb_cam_capture_centroid.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_centroid
// Drives camera frames built from an image array and compares every frame
// buffer write and the per-frame centroid against a reference computed from
// the image with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_cam_capture_centroid;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        testmode;
   logic [2:0]  rgbfilter;
   logic        fb_we;
   logic [12:0] fb_addr;
   logic [11:0] fb_wdata;
   logic [6:0]  cent_col;
   logic [5:0]  cent_row;
   logic        cent_valid;
   logic        frame_done;

   always #5 clk = ~clk;

   cam_capture_centroid dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cam_vsync  (cam_vsync),
      .cam_href   (cam_href),
      .cam_data   (cam_data),
      .testmode   (testmode),
      .rgbfilter  (rgbfilter),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .cent_col   (cent_col),
      .cent_row   (cent_row),
      .cent_valid (cent_valid),
      .frame_done (frame_done)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   int got_addr[$];
   int got_data[$];
   int fd_cnt    = 0;
   int cap_col   = 0;
   int cap_row   = 0;
   int cap_valid = 0;

   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         got_addr.push_back(int'(fb_addr));
         got_data.push_back(int'(fb_wdata));
      end
      if (frame_done === 1'b1) begin
         fd_cnt    <= fd_cnt + 1;
         cap_col   <= int'(cent_col);
         cap_row   <= int'(cent_row);
         cap_valid <= int'(cent_valid);
      end
   end

   // ---------------- image and reference ----------------
   logic [11:0] img [0:125][0:169];
   int line_len [0:125];
   int n_rows;
   int part_k;          // -1: frame ends cleanly; else pixels in a cut-off last line
   int rst_row = -1;    // line at which reset is pulsed, -1 for none
   int rst_mark_w, rst_mark_fd;
   int exp_addr[$];
   int exp_data[$];
   int m_cent_col = 0, m_cent_row = 0, m_valid = 0;
   int last_base, last_n;

   function automatic int is_match(input int px, input int filt);
      int comp [3];
      int want_hi;
      if (filt == 0) return 0;
      comp[0] = (px >> 8) & 15;
      comp[1] = (px >> 4) & 15;
      comp[2] = px & 15;
      for (int i = 0; i < 3; i++) begin
         want_hi = (filt >> (2 - i)) & 1;
         if (want_hi == 1 && comp[i] < 8) return 0;
         if (want_hi == 0 && comp[i] >= 6) return 0;
      end
      return 1;
   endfunction

   function automatic int tp_model(input int sc);
      int v = 0;
      if ((sc / 64) % 2 == 1) v += 'hF00;
      if ((sc / 32) % 2 == 1) v += 'h0F0;
      if ((sc / 16) % 2 == 1) v += 'h00F;
      return v;
   endfunction

   task automatic model_frame(input int filt, input int tm);
      int mnc = 1000, mxc = -1, mnr = 1000, mxr = -1;
      int px, sc, sr, src, m;
      exp_addr.delete();
      exp_data.delete();
      for (int r = 0; r <= n_rows; r++) begin
         for (int c = 0; c < line_len[r]; c++) begin
            if (r < 120 && c < 160 && r % 2 == 0 && c % 2 == 0) begin
               px  = int'(img[r][c]);
               sc  = c / 2;
               sr  = r / 2;
               src = (tm != 0) ? tp_model(sc) : px;
               m   = is_match(px, filt);
               exp_addr.push_back(sr * 80 + sc);
               exp_data.push_back((filt == 0 || m == 1) ? src : 0);
               if (m == 1) begin
                  if (sc < mnc) mnc = sc;
                  if (sc > mxc) mxc = sc;
                  if (sr < mnr) mnr = sr;
                  if (sr > mxr) mxr = sr;
               end
            end
         end
      end
      if (mxc >= 0) begin
         m_cent_col = (mnc + mxc) / 2;
         m_cent_row = (mnr + mxr) / 2;
         m_valid    = 1;
      end else begin
         m_valid    = 0;
      end
   endtask

   function automatic logic [11:0] rand_px();
      case ($urandom_range(0, 7))
         0:       return 12'hF00;
         1:       return 12'h0F0;
         2:       return 12'h00F;
         3:       return 12'h8F0;
         4:       return 12'hFF0;
         5:       return 12'h000;
         6:       return 12'h9A5;
         default: return 12'($urandom);
      endcase
   endfunction

   // ---------------- camera driver ----------------
   task automatic drive_idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cam_href = 1'b0;
      end
   endtask

   task automatic send_pixel(input logic [11:0] px);
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = {4'($urandom), px[11:8]};
      @(negedge clk);
      cam_data = px[7:0];
   endtask

   task automatic send_frame(input int filt, input int tm);
      logic [11:0] px;
      logic [2:0]  f3;
      f3 = 3'(filt);
      @(negedge clk);
      cam_href  = 1'b0;
      rgbfilter = f3;
      testmode  = 1'(tm);
      cam_vsync = 1'b1;
      repeat (3) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (2) @(negedge clk);
      // configuration is latched at frame start; scramble it afterwards
      rgbfilter = 3'($urandom);
      testmode  = 1'($urandom);
      drive_idle(3);
      for (int r = 0; r < n_rows; r++) begin
         if (r == rst_row) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = 8'($urandom);
            @(negedge clk);
            rst_n       = 1'b0;
            rst_mark_w  = got_addr.size();
            rst_mark_fd = fd_cnt;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            drive_idle(2);
         end
         for (int c = 0; c < line_len[r]; c++) send_pixel(img[r][c]);
         drive_idle(4);
      end
      if (part_k >= 0) begin
         for (int c = 0; c < part_k; c++) send_pixel(img[n_rows][c]);
         px = img[n_rows][part_k];
         @(negedge clk);
         cam_href = 1'b1;
         cam_data = {4'($urandom), px[11:8]};
         @(negedge clk);
         cam_vsync = 1'b1;
         cam_data  = px[7:0];
         @(negedge clk);
         cam_href = 1'b0;
      end else begin
         @(negedge clk);
         cam_vsync = 1'b1;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic run_frame(input string name, input int filt, input int tm);
      int fdb, e0;
      last_base = got_addr.size();
      fdb       = fd_cnt;
      model_frame(filt, tm);
      send_frame(filt, tm);
      last_n = got_addr.size() - last_base;
      check_val({name, " writes"}, last_n, exp_addr.size());
      for (int i = 0; i < last_n && i < exp_addr.size(); i++) begin
         e0 = n_err;
         check_val({name, " addr"}, got_addr[last_base + i], exp_addr[i]);
         check_val({name, " data"}, got_data[last_base + i], exp_data[i]);
         if (n_err != e0) break;
      end
      check_val({name, " frame_done"}, fd_cnt - fdb, 1);
      check_val({name, " cent_valid"}, cap_valid, m_valid);
      check_val({name, " cent_col"}, cap_col, m_cent_col);
      check_val({name, " cent_row"}, cap_row, m_cent_row);
   endtask

   task automatic set_flat(input int rows, input int len, input logic [11:0] px);
      n_rows = rows;
      part_k = -1;
      for (int r = 0; r <= 125; r++) begin
         line_len[r] = (r < rows) ? len : 0;
         for (int c = 0; c < 170; c++) img[r][c] = px;
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      int max_a;
      rst_n     = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      testmode  = 1'b0;
      rgbfilter = 3'b000;
      repeat (3) @(negedge clk);
      check_val("rst fb_we",      32'(fb_we),      0);
      check_val("rst fb_addr",    32'(fb_addr),    0);
      check_val("rst fb_wdata",   32'(fb_wdata),   0);
      check_val("rst cent_col",   32'(cent_col),   0);
      check_val("rst cent_row",   32'(cent_row),   0);
      check_val("rst cent_valid", 32'(cent_valid), 0);
      check_val("rst frame_done", 32'(frame_done), 0);
      rst_n = 1'b1;

      // oversized frame (170 px x 125 lines) of solid red, no filter
      set_flat(125, 170, 12'hF00);
      run_frame("full", 0, 0);
      max_a = -1;
      for (int i = 0; i < last_n; i++)
         if (got_addr[last_base + i] > max_a) max_a = got_addr[last_base + i];
      check_val("full count", last_n, 4800);
      check_val("full max addr", max_a, 4799);
      check_val("full first addr", got_addr[last_base], 0);
      check_val("full valid", cap_valid, 0);

      // red block at stored cols 10..19, rows 20..29, red filter
      set_flat(60, 40, 12'h000);
      for (int r = 40; r < 60; r++)
         for (int c = 20; c < 40; c++) img[r][c] = 12'hF00;
      run_frame("block", 4, 0);
      check_val("block cent_col", cap_col, 14);
      check_val("block cent_row", cap_row, 24);
      check_val("block valid", cap_valid, 1);

      // green filter: 8F0 rejected, 0F0 passes
      set_flat(2, 4, 12'h000);
      img[0][0] = 12'h8F0;
      img[0][2] = 12'h0F0;
      run_frame("green", 2, 0);
      check_val("green 8F0", got_data[last_base], 12'h000);
      check_val("green 0F0", got_data[last_base + 1], 12'h0F0);

      // test pattern
      set_flat(1, 100, 12'h000);
      for (int c = 0; c < 100; c++) img[0][c] = rand_px();
      run_frame("tpat", 0, 1);
      check_val("tpat col16", got_data[last_base + 16], 12'h00F);
      check_val("tpat col48", got_data[last_base + 48], 12'h0FF);

      // random frames, some cut off mid-line / mid-pixel by vsync
      for (int f = 0; f < 3; f++) begin
         set_flat($urandom_range(16, 40), 0, 12'h000);
         for (int r = 0; r < n_rows; r++) line_len[r] = $urandom_range(20, 48);
         if ($urandom_range(0, 1) == 1) begin
            part_k           = $urandom_range(0, 10);
            line_len[n_rows] = part_k;
         end
         for (int r = 0; r <= n_rows; r++)
            for (int c = 0; c < 64; c++) img[r][c] = rand_px();
         run_frame("rand", $urandom_range(0, 7), $urandom_range(0, 1));
      end

      // reset in the middle of a frame at camera line 30
      set_flat(40, 60, 12'hF00);
      rst_row = 30;
      send_frame(0, 0);
      rst_row = -1;
      check_val("rst-mid writes", got_addr.size() - rst_mark_w, 0);
      check_val("rst-mid frame_done", fd_cnt - rst_mark_fd, 0);
      check_val("rst-mid cent_col", 32'(cent_col), 0);
      m_cent_col = 0;
      m_cent_row = 0;
      run_frame("after-rst", 0, 0);
      check_val("after-rst first addr", got_addr[last_base], 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
